// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   // Which requester a memory transaction belongs to.
   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   // IDLE arbitrates every cycle; HOLD_x pins the owner while its request waits for gnt.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } arb_state_e;

   // Fetches always read a full word.
   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch, LSU and memory req/gnt/rvalid buses around the arbiter.
// Latency: n/a (wires only).
// Backpressure: mem_gnt_i throttles requests; responses cannot be stalled.
// Ports: instr_* = fetch port, data_* = LSU port, mem_* = shared memory bus.
// Modport slave is the arbiter's view; modport master is the environment's view.
interface imem_dmem_arbiter_if;

   // fetch port
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic        instr_err_o;
   logic [31:0] instr_rdata_o;

   // LSU port
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic [31:0] data_rdata_o;

   // shared memory bus
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic        mem_err_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
      output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
      output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
      input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
      input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/imem_dmem_arbiter_owner_fifo.sv
// 1-bit-wide FIFO recording the owner of each accepted memory transaction.
// Latency: push visible at head one cycle later; registers only, no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rstn, push/din, pop, head (oldest entry), full, empty.
module owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   // Pointers carry one spare bit and wrap at DEPTH; the storage index is the low bits.
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2**IW-1:0] store;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == PW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = store[rd_ptr[IW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         store  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr[IW-1:0]] <= din;
            wr_ptr                <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory bus between fetch and LSU; data wins unless fetch is starved.
// Latency: request and response paths are combinational (0 cycles).
// Backpressure: mem_gnt_i stalls the owner; issue stops once MAX_OUTSTANDING are in flight.
// Ports: clk, rstn (async active-low), bus (imem_dmem_arbiter_if.slave).
module imem_dmem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   imem_dmem_arbiter_if.slave    bus
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    state_q;
   arb_state_e    state_d;
   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;
   owner_e        owner;
   logic          owner_req;
   logic          starved;
   logic          issue;
   logic          accept;
   logic          instr_gnt;
   logic          resp_vld;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_head;

   assign starved = (starve_q == CW'(STARVE_LIMIT));

   // Owner is re-chosen only in IDLE; a pending request keeps its owner so the
   // address on the bus cannot change under the memory.
   always_comb begin
      owner = OWN_DATA;
      case (state_q)
         HOLD_I:  owner = OWN_INSTR;
         HOLD_D:  owner = OWN_DATA;
         default: owner = (starved || !bus.data_req_i) ? OWN_INSTR : OWN_DATA;
      endcase
   end

   assign owner_req = (owner == OWN_INSTR) ? bus.instr_req_i : bus.data_req_i;
   // A full FIFO blocks issue outright, even in a cycle that also pops.
   assign issue     = rstn && owner_req && !fifo_full;
   assign accept    = issue && bus.mem_gnt_i;
   assign instr_gnt = accept && (owner == OWN_INSTR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (issue && !bus.mem_gnt_i) begin
               state_d = (owner == OWN_INSTR) ? HOLD_I : HOLD_D;
            end
         end
         HOLD_I, HOLD_D: begin
            if (bus.mem_gnt_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      starve_d = '0;
      if (bus.instr_req_i && !instr_gnt) begin
         starve_d = starved ? starve_q : starve_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (accept),
      .din   (owner == OWN_DATA),
      .pop   (bus.mem_rvalid_i),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Responses with nothing outstanding (e.g. stale ones after a reset) are dropped.
   assign resp_vld = rstn && bus.mem_rvalid_i && !fifo_empty;

   // Request mux; every output is forced low while reset is held.
   assign bus.mem_req_o   = issue;
   assign bus.mem_we_o    = rstn && (owner == OWN_DATA) && bus.data_we_i;
   assign bus.mem_be_o    = !rstn ? 4'h0 :
                            (owner == OWN_DATA) ? bus.data_be_i : BE_FULL;
   assign bus.mem_addr_o  = !rstn ? 32'h0 :
                            (owner == OWN_DATA) ? bus.data_addr_i : bus.instr_addr_i;
   assign bus.mem_wdata_o = (rstn && (owner == OWN_DATA)) ? bus.data_wdata_i : 32'h0;

   assign bus.instr_gnt_o = instr_gnt;
   assign bus.data_gnt_o  = accept && (owner == OWN_DATA);

   // Response steering by the oldest outstanding owner.
   assign bus.instr_rvalid_o = resp_vld && (fifo_head == OWN_INSTR);
   assign bus.data_rvalid_o  = resp_vld && (fifo_head == OWN_DATA);
   assign bus.instr_err_o    = resp_vld && bus.mem_err_i && (fifo_head == OWN_INSTR);
   assign bus.data_err_o     = resp_vld && bus.mem_err_i && (fifo_head == OWN_DATA);
   assign bus.instr_rdata_o  = rstn ? bus.mem_rdata_i : 32'h0;
   assign bus.data_rdata_o   = rstn ? bus.mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scenario bench for imem_dmem_arbiter: expected responses are queued at grant
// time and popped when the bench's memory model returns rvalid.
module tb_imem_dmem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   imem_dmem_arbiter_if bus();

   imem_dmem_arbiter #(
      .MAX_OUTSTANDING (2),
      .STARVE_LIMIT    (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      owner_e      owner;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = 32'h0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'h0;
      bus.data_addr_i  = 32'h0;
      bus.data_wdata_i = 32'h0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
      bus.mem_rdata_i  = 32'h0;
   endtask

   // Memory model: answer the oldest queued transaction when allowed.
   task automatic drive_resp(input logic allow);
      bus.mem_rvalid_i = allow && (sb.size() != 0);
      bus.mem_rdata_i  = bus.mem_rvalid_i ? sb[0].rdata : 32'h0;
      bus.mem_err_i    = bus.mem_rvalid_i ? sb[0].err : 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'h5;
      bus.data_addr_i  = 32'h44;
      bus.data_wdata_i = 32'h1234;
      bus.mem_gnt_i    = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hCAFE;
      next_cycle();
      #4;
      vectors++;
      if ({bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o,
           bus.data_gnt_o, bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o,
           bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: mem_req=%b gnt=%b%b rvalid=%b%b addr=%h rdata=%h want all 0",
                  bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
                  bus.data_rvalid_o, bus.mem_addr_o, bus.instr_rdata_o);
      end
      idle_inputs();
      next_cycle();
      rstn = 1'b1;
      next_cycle();
      #4;
      vectors++;
      if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_idle: req/gnt/rvalid=%b%b%b%b%b want 00000", bus.mem_req_o,
                  bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o);
      end
      next_cycle();
   endtask

   // Both requesters contend with immediate gnt: data wins 4 times, fetch on the 5th,
   // and with fetch still asking afterwards data wins again (counter back at 0).
   task automatic test_starvation();
      exp_t e;
      logic exp_i;
      idle_inputs();
      bus.instr_addr_i = 32'h0;
      bus.data_addr_i  = 32'h80;
      bus.data_be_i    = 4'hF;
      bus.mem_gnt_i    = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.instr_req_i = (k < 6);
         bus.data_req_i  = (k < 6);
         drive_resp(1'b1);
         #4;
         if (bus.mem_rvalid_i) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o} !==
                {e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata, e.rdata}) begin
               miscompares++;
               $display("FAIL starve_resp k=%0d: rvalid i/d=%b%b rdata=%h want %b%b %h", k,
                        bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o,
                        e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata);
            end
         end
         if (k < 6) begin
            exp_i = (k == 4);
            vectors++;
            if ({bus.instr_gnt_o, bus.data_gnt_o} !== {exp_i, !exp_i}) begin
               miscompares++;
               $display("FAIL starve_gnt k=%0d: gnt i/d=%b%b want %b%b", k,
                        bus.instr_gnt_o, bus.data_gnt_o, exp_i, !exp_i);
            end
            e.owner = exp_i ? OWN_INSTR : OWN_DATA;
            e.rdata = 32'h1000 + 32'(k);
            e.err   = 1'b0;
            sb.push_back(e);
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   // Data stalls in HOLD_D at 0x100 while fetch also asks; fetch wins once data is gone.
   task automatic test_hold();
      exp_t e;
      idle_inputs();
      bus.data_addr_i  = 32'h100;
      bus.data_be_i    = 4'hF;
      bus.instr_addr_i = 32'h200;
      for (int k = 0; k < 6; k++) begin
         bus.data_req_i  = (k <= 3);
         bus.instr_req_i = (k >= 1) && (k <= 4);
         bus.mem_gnt_i   = (k >= 3);
         drive_resp(1'b1);
         #4;
         if (bus.mem_rvalid_i) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o} !==
                {e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata}) begin
               miscompares++;
               $display("FAIL hold_resp k=%0d: rvalid i/d=%b%b rdata=%h want %b%b %h", k,
                        bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o,
                        e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata);
            end
         end
         if (k <= 3) begin
            vectors++;
            if ({bus.mem_req_o, bus.mem_addr_o, bus.data_gnt_o, bus.instr_gnt_o} !==
                {1'b1, 32'h100, k == 3, 1'b0}) begin
               miscompares++;
               $display("FAIL hold_data k=%0d: req=%b addr=%h gnt d/i=%b%b want 1 00000100 %b0", k,
                        bus.mem_req_o, bus.mem_addr_o, bus.data_gnt_o, bus.instr_gnt_o, k == 3);
            end
            if (k == 3) begin
               e.owner = OWN_DATA; e.rdata = 32'h2000; e.err = 1'b0;
               sb.push_back(e);
            end
         end else if (k == 4) begin
            vectors++;
            if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_we_o} !==
                {1'b1, 1'b0, 32'h200, 4'hF, 1'b0}) begin
               miscompares++;
               $display("FAIL hold_fetch: gnt i/d=%b%b addr=%h be=%h we=%b want 10 00000200 f 0",
                        bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_we_o);
            end
            e.owner = OWN_INSTR; e.rdata = 32'h2001; e.err = 1'b0;
            sb.push_back(e);
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   // Fetch then data write are both issued before either answer returns.
   task automatic test_order();
      exp_t e;
      idle_inputs();
      bus.mem_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.instr_req_i  = (k == 0);
         bus.instr_addr_i = 32'h0;
         bus.data_req_i   = (k == 1);
         bus.data_we_i    = (k == 1);
         bus.data_be_i    = 4'b0011;
         bus.data_addr_i  = 32'h40;
         bus.data_wdata_i = 32'h5555_7777;
         drive_resp(k >= 2);
         #4;
         if (bus.mem_rvalid_i) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o} !==
                {e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata, e.rdata}) begin
               miscompares++;
               $display("FAIL order_resp k=%0d: rvalid i/d=%b%b rdata=%h want %b%b %h", k,
                        bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o,
                        e.owner == OWN_INSTR, e.owner == OWN_DATA, e.rdata);
            end
         end
         if (k == 0) begin
            vectors++;
            if ({bus.instr_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h0}) begin
               miscompares++;
               $display("FAIL order_fetch: gnt=%b we=%b be=%h addr=%h want 1 0 f 0",
                        bus.instr_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
            end
            e.owner = OWN_INSTR; e.rdata = 32'hAAAA; e.err = 1'b0;
            sb.push_back(e);
         end else if (k == 1) begin
            vectors++;
            if ({bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !==
                {1'b1, 1'b1, 4'b0011, 32'h40, 32'h5555_7777}) begin
               miscompares++;
               $display("FAIL order_write: gnt=%b we=%b be=%h addr=%h wdata=%h want 1 1 3 40 55557777",
                        bus.data_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
            end
            e.owner = OWN_DATA; e.rdata = 32'hBBBB; e.err = 1'b0;
            sb.push_back(e);
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   // Two outstanding fill the owner FIFO; issue resumes only the cycle after a pop.
   task automatic test_full();
      exp_t e;
      logic exp_req;
      idle_inputs();
      bus.instr_addr_i = 32'h10;
      bus.mem_gnt_i    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.instr_req_i = (k <= 5);
         drive_resp(k == 4 || k >= 6);
         #4;
         if (bus.mem_rvalid_i) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o} !== {2'b10, e.rdata}) begin
               miscompares++;
               $display("FAIL full_resp k=%0d: rvalid i/d=%b%b rdata=%h want 10 %h", k,
                        bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, e.rdata);
            end
         end
         if (k <= 5) begin
            exp_req = (k <= 1) || (k == 5);
            vectors++;
            if ({bus.mem_req_o, bus.instr_gnt_o} !== {exp_req, exp_req}) begin
               miscompares++;
               $display("FAIL full_issue k=%0d: mem_req=%b gnt=%b want %b %b", k,
                        bus.mem_req_o, bus.instr_gnt_o, exp_req, exp_req);
            end
            if (exp_req) begin
               e.owner = OWN_INSTR; e.rdata = 32'h3000 + 32'(k); e.err = 1'b0;
               sb.push_back(e);
            end
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   // Unsolicited rvalid is dropped; an error on a fetch response goes only to fetch.
   task automatic test_err();
      exp_t e;
      idle_inputs();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_err_i    = 1'b1;
      bus.mem_rdata_i  = 32'hDEAD;
      #4;
      vectors++;
      if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o} !== 4'b0) begin
         miscompares++;
         $display("FAIL empty_drop: rvalid i/d=%b%b err i/d=%b%b want 0000",
                  bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o);
      end
      next_cycle();
      idle_inputs();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h400;
      bus.mem_gnt_i    = 1'b1;
      #4;
      vectors++;
      if (bus.instr_gnt_o !== 1'b1) begin
         miscompares++;
         $display("FAIL err_gnt: gnt=%b want 1", bus.instr_gnt_o);
      end
      e.owner = OWN_INSTR; e.rdata = 32'h4000; e.err = 1'b1;
      sb.push_back(e);
      next_cycle();
      idle_inputs();
      drive_resp(1'b1);
      #4;
      if (bus.mem_rvalid_i) begin
         e = sb.pop_front();
         vectors++;
         if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o, bus.instr_rdata_o} !==
             {1'b1, 1'b0, e.err, 1'b0, e.rdata}) begin
            miscompares++;
            $display("FAIL err_route: rvalid i/d=%b%b err i/d=%b%b rdata=%h want 10 10 %h",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o,
                     bus.instr_rdata_o, e.rdata);
         end
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   // Reset with two transactions in flight; their late answers must be dropped.
   task automatic test_reset_mid();
      exp_t e;
      idle_inputs();
      bus.mem_gnt_i    = 1'b1;
      bus.instr_addr_i = 32'h500;
      bus.data_addr_i  = 32'h600;
      bus.data_be_i    = 4'hF;
      bus.instr_req_i  = 1'b1;
      next_cycle();
      bus.instr_req_i  = 1'b0;
      bus.data_req_i   = 1'b1;
      next_cycle();
      rstn = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hBEEF;
      #4;
      vectors++;
      if ({bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o,
           bus.data_gnt_o, bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o,
           bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
         miscompares++;
         $display("FAIL midreset_outputs: mem_req=%b gnt=%b%b rvalid=%b%b addr=%h want all 0",
                  bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
                  bus.data_rvalid_o, bus.mem_addr_o);
      end
      next_cycle();
      rstn = 1'b1;
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         idle_inputs();
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = 32'hDEAD_0000 + 32'(k);
         #4;
         vectors++;
         if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL stale_drop k=%0d: rvalid i/d=%b%b want 00", k,
                     bus.instr_rvalid_o, bus.data_rvalid_o);
         end
         next_cycle();
      end
      idle_inputs();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h700;
      bus.mem_gnt_i    = 1'b1;
      #4;
      vectors++;
      if ({bus.mem_req_o, bus.instr_gnt_o, bus.mem_addr_o} !== {2'b11, 32'h700}) begin
         miscompares++;
         $display("FAIL post_reset_fetch: req=%b gnt=%b addr=%h want 1 1 00000700",
                  bus.mem_req_o, bus.instr_gnt_o, bus.mem_addr_o);
      end
      e.owner = OWN_INSTR; e.rdata = 32'h7777; e.err = 1'b0;
      sb.push_back(e);
      next_cycle();
      idle_inputs();
      drive_resp(1'b1);
      #4;
      if (bus.mem_rvalid_i) begin
         e = sb.pop_front();
         vectors++;
         if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o} !== {2'b10, e.rdata}) begin
            miscompares++;
            $display("FAIL post_reset_resp: rvalid i/d=%b%b rdata=%h want 10 %h",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, e.rdata);
         end
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_starvation();
      test_hold();
      test_order();
      test_full();
      test_err();
      test_reset_mid();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d responses never returned, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
